// File: rtl/aes_sub_bytes.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes
//
// Iterative AES byte substitution (SubBytes / SubWord and their inverses).
// A block of NUM_BYTES bytes is captured and then rewritten in place. Each
// clock rewrites LANES bytes through the S-box, so one block takes
// K = NUM_BYTES/LANES clocks in SUB.
//
// FSM: IDLE -> SUB (K edges) -> DONE -> IDLE.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds data stable while valid is
// high and ready is low. ready/valid outputs here depend only on FSM state,
// never combinationally on the partner's valid/ready.
//
// Parameters:
//   NUM_BYTES  bytes per block (4 = SubWord, 16 = SubBytes)
//   LANES      S-box lookups per clock; must divide NUM_BYTES
//   INV_EN     1 = inverse S-box built and selectable, 0 = forward only
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input block valid
//   in_ready   block can be accepted (IDLE)
//   in_data    input bytes, byte i = in_data[8i+7:8i]
//   in_inv     1 = inverse substitution, sampled with in_data
//   out_valid  result valid (DONE)
//   out_ready  downstream accepts result
//   out_data   substituted bytes, same ordering as in_data
//   busy       high in SUB or DONE
// ---------------------------------------------------------------------------
module aes_sub_bytes #(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4,
    parameter int INV_EN    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int K  = NUM_BYTES / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    // Reject geometries where the lanes do not tile the block.
    generate
        if (LANES < 1 || NUM_BYTES < 1 || (NUM_BYTES % LANES) != 0) begin : g_bad_geometry
            $error("aes_sub_bytes: NUM_BYTES must be a positive multiple of LANES");
        end
    endgenerate

    // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, same layout.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // row = high nibble, column = low nibble, i.e. plain index x.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX_TBL[8*(255 - int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return INV_SBOX_TBL[8*(255 - int'(x)) +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [8*NUM_BYTES-1:0] data_q, data_d;
    logic                   mode_q, mode_d;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];
    logic       inv_sel;

    // With INV_EN=0 the inverse path folds away as constant-false.
    assign inv_sel = (INV_EN != 0) && mode_q;

    // The LANES bytes of the current group.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_in[k]  = data_q[8*(int'(cnt_q)*LANES + k) +: 8];
            lane_out[k] = inv_sel ? sbox_inv(lane_in[k]) : sbox_fwd(lane_in[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = (INV_EN != 0) ? in_inv : 1'b0;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                for (int k = 0; k < LANES; k++) begin
                    data_d[8*(int'(cnt_q)*LANES + k) +: 8] = lane_out[k];
                end
                if (cnt_q == CW'(K - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_aes_sub_bytes.sv
// ---------------------------------------------------------------------------
// tb_aes_sub_bytes
//
// Directed bench for aes_sub_bytes. Six instances cover the parameter
// combinations of interest:
//   0: NUM_BYTES=16 LANES=4  INV_EN=1 (defaults)
//   1: NUM_BYTES=16 LANES=4  INV_EN=0
//   2: NUM_BYTES=16 LANES=1  INV_EN=1
//   3: NUM_BYTES=16 LANES=16 INV_EN=1
//   4: NUM_BYTES=4  LANES=1  INV_EN=1
//   5: NUM_BYTES=4  LANES=4  INV_EN=1
// All inputs are driven on the falling edge and outputs sampled there.
// ---------------------------------------------------------------------------
module tb_aes_sub_bytes;

    logic         clk;
    logic         rst_n;
    logic [5:0]   in_valid_v;
    wire  [5:0]   in_ready_v;
    wire  [5:0]   out_valid_v;
    wire  [5:0]   busy_v;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_ready;
    wire  [127:0] od0, od1, od2, od3;
    wire  [31:0]  od4, od5;

    int tests_run;
    int tests_failed;

    int k_of [6] = '{4, 4, 16, 1, 4, 1};
    int nb_of[6] = '{16, 16, 16, 16, 4, 4};

    // Vectors for the directed checks.
    localparam logic [127:0] FWD_IN  = 128'h00000000_00000000_00002010_01ff5300;
    localparam logic [127:0] FWD_EXP = 128'h63636363_63636363_6363b7ca_7c16ed63;
    localparam logic [127:0] INV_IN  = 128'h00000000_00000000_00000000_7c16ed63;
    localparam logic [127:0] INV_EXP = 128'h52525252_52525252_52525252_01ff5300;
    localparam logic [127:0] NOINV_EXP = 128'h63636363_63636363_63636363_104755fb;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    aes_sub_bytes #(.NUM_BYTES(16), .LANES(4), .INV_EN(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_data(od0), .busy(busy_v[0]));

    aes_sub_bytes #(.NUM_BYTES(16), .LANES(4), .INV_EN(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_data(od1), .busy(busy_v[1]));

    aes_sub_bytes #(.NUM_BYTES(16), .LANES(1), .INV_EN(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .out_data(od2), .busy(busy_v[2]));

    aes_sub_bytes #(.NUM_BYTES(16), .LANES(16), .INV_EN(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid_v[3]),
        .out_ready(out_ready), .out_data(od3), .busy(busy_v[3]));

    aes_sub_bytes #(.NUM_BYTES(4), .LANES(1), .INV_EN(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
        .in_data(in_data[31:0]), .in_inv(in_inv), .out_valid(out_valid_v[4]),
        .out_ready(out_ready), .out_data(od4), .busy(busy_v[4]));

    aes_sub_bytes #(.NUM_BYTES(4), .LANES(4), .INV_EN(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[5]), .in_ready(in_ready_v[5]),
        .in_data(in_data[31:0]), .in_inv(in_inv), .out_valid(out_valid_v[5]),
        .out_ready(out_ready), .out_data(od5), .busy(busy_v[5]));

    function automatic logic [127:0] pick(input int sel);
        case (sel)
            0:       return od0;
            1:       return od1;
            2:       return od2;
            3:       return od3;
            4:       return {96'b0, od4};
            default: return {96'b0, od5};
        endcase
    endfunction

    // ---------------- driver ----------------
    // Pushes one block into instance sel, waits for the result, returns it
    // with the number of clock edges from accept to out_valid, then completes
    // the output handshake. ok=0 if any bounded wait expired.
    task automatic run_block(input int sel, input logic [127:0] data, input logic inv,
                             output logic [127:0] result, output int lat, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready_v[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[sel]) ok = 1'b0;
        in_data         = data;
        in_inv          = inv;
        in_valid_v[sel] = 1'b1;
        @(negedge clk);
        in_valid_v[sel] = 1'b0;
        in_inv          = 1'b0;
        n = 0;
        while (!out_valid_v[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_v[sel]) ok = 1'b0;
        lat    = n;
        result = pick(sel);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready_v[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready_v[0]);
        end
        tests_run++;
        if (out_valid_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid_v[0]);
        end
        tests_run++;
        if (busy_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got=%b exp=0", busy_v[0]);
        end
        tests_run++;
        if (od0 !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_out_data got=%h exp=0", od0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready_v !== 6'b111111) begin
            tests_failed++;
            $display("FAIL post_reset_in_ready got=%b exp=111111", in_ready_v);
        end
    endtask

    task automatic test_forward();
        logic [127:0] r;
        int lat;
        bit ok;
        run_block(0, FWD_IN, 1'b0, r, lat, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL fwd_timeout got=0 exp=1");
        end
        tests_run++;
        if (r !== FWD_EXP) begin
            tests_failed++;
            $display("FAIL fwd_data got=%h exp=%h", r, FWD_EXP);
        end
        tests_run++;
        if (lat != 4) begin
            tests_failed++;
            $display("FAIL fwd_latency got=%0d exp=4", lat);
        end
    endtask

    task automatic test_inverse();
        logic [127:0] r;
        int lat;
        bit ok;
        run_block(0, INV_IN, 1'b1, r, lat, ok);
        tests_run++;
        if (!ok || r !== INV_EXP) begin
            tests_failed++;
            $display("FAIL inv_data got=%h exp=%h", r, INV_EXP);
        end
        // Forward-only build ignores in_inv.
        run_block(1, INV_IN, 1'b1, r, lat, ok);
        tests_run++;
        if (!ok || r !== NOINV_EXP) begin
            tests_failed++;
            $display("FAIL noinv_data got=%h exp=%h", r, NOINV_EXP);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] held;
        int n;
        @(negedge clk);
        in_data       = FWD_IN;
        in_inv        = 1'b0;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        // Attempted capture while in SUB must be ignored.
        in_data       = {128{1'b1}};
        in_inv        = 1'b1;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        in_inv        = 1'b0;
        n = 0;
        while (!out_valid_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        held = od0;
        tests_run++;
        if (!out_valid_v[0] || held !== FWD_EXP) begin
            tests_failed++;
            $display("FAIL bp_data got=%h exp=%h", held, FWD_EXP);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (od0 !== FWD_EXP || in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d got=%h/%b/%b exp=%h/0/1", i, od0, in_ready_v[0],
                         out_valid_v[0], FWD_EXP);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release got=%b/%b/%b exp=1/0/0", in_ready_v[0], out_valid_v[0],
                     busy_v[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        in_data       = FWD_IN;
        in_inv        = 1'b0;
        in_valid_v[0] = 1'b1;
        out_ready     = 1'b1;
        n = 0;
        while (!out_valid_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        tests_run++;
        if (out_valid_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_pulse got=%b exp=0", out_valid_v[0]);
        end
        n = 1;
        while (!out_valid_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n != 6) begin
            tests_failed++;
            $display("FAIL b2b_period got=%0d exp=6", n);
        end
        tests_run++;
        if (od0 !== FWD_EXP) begin
            tests_failed++;
            $display("FAIL b2b_data got=%h exp=%h", od0, FWD_EXP);
        end
        in_valid_v[0] = 1'b0;
        n = 0;
        while (!in_ready_v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_sub();
        logic [127:0] r;
        int lat;
        bit ok;
        @(negedge clk);
        in_data       = INV_IN;
        in_inv        = 1'b0;
        in_valid_v[0] = 1'b1;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_flags got=%b/%b/%b exp=0/1/0", out_valid_v[0],
                     in_ready_v[0], busy_v[0]);
        end
        tests_run++;
        if (od0 !== 128'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_data got=%h exp=0", od0);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_pulse got=%b exp=0", out_valid_v[0]);
        end
        rst_n = 1'b1;
        run_block(0, FWD_IN, 1'b0, r, lat, ok);
        tests_run++;
        if (!ok || r !== FWD_EXP || lat != 4) begin
            tests_failed++;
            $display("FAIL rst_mid_next got=%h lat=%0d exp=%h lat=4", r, lat, FWD_EXP);
        end
    endtask

    task automatic test_round_trip(input int sel);
        logic [127:0] orig, r1, r2;
        int lat1, lat2, nb, k;
        bit ok1, ok2;
        nb = nb_of[sel];
        k  = k_of[sel];
        for (int b = 0; b < 256 / nb; b++) begin
            orig = '0;
            for (int i = 0; i < nb; i++) orig[8*i +: 8] = 8'(b*nb + i);
            run_block(sel, orig, 1'b0, r1, lat1, ok1);
            run_block(sel, r1, 1'b1, r2, lat2, ok2);
            tests_run++;
            if (!ok1 || !ok2 || r2 !== orig) begin
                tests_failed++;
                $display("FAIL rt_data_i%0d_b%0d got=%h exp=%h", sel, b, r2, orig);
            end
            tests_run++;
            if (lat1 != k || lat2 != k) begin
                tests_failed++;
                $display("FAIL rt_latency_i%0d_b%0d got=%0d/%0d exp=%0d", sel, b, lat1, lat2, k);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid_v   = '0;
        in_data      = '0;
        in_inv       = 1'b0;
        out_ready    = 1'b0;

        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_sub();
        test_round_trip(0);
        test_round_trip(2);
        test_round_trip(3);
        test_round_trip(4);
        test_round_trip(5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes.md
AES_SUB_BYTES -- requirements
Module: aes_sub_bytes

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 16: bytes per transfer; 4 gives SubWord, 16 gives SubBytes.
REQ-002 SHALL have parameter LANES, default 4: S-box lookups per clock. NUM_BYTES mod LANES != 0 SHALL fail elaboration.
REQ-003 SHALL have parameter INV_EN, default 1: 1 includes the inverse S-box; 0 builds forward only.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  block can accept input.
- in_data  in  8*NUM_BYTES  bytes; byte i = in_data[8i+7:8i].
- in_inv  in  1  1 = inverse S-box; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  8*NUM_BYTES  substituted bytes, same ordering as in_data.
- busy  out  1  high in SUB or DONE.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, SUB, DONE. K = NUM_BYTES/LANES.
REQ-006 IDLE:
- in_ready=1.
- On in_valid&&in_ready at a clock edge: capture in_data into an internal byte register, capture mode, clear group counter to 0, go to SUB.
REQ-007 SUB:
- Each edge, byte j = cnt*LANES+k (k=0..LANES-1) is replaced in place by SBOX[byte j], or INV_SBOX[byte j] when mode=1.
- Lookup index: row = high nibble, column = low nibble.
- cnt increments by 1.
REQ-008 On the edge that processes group K-1, the FSM SHALL go to DONE and cnt SHALL wrap to 0. When K=1, SUB lasts exactly one edge.
REQ-009 DONE:
- out_valid=1; out_data = the register, held stable while out_ready=0.
- On out_valid&&out_ready the FSM SHALL go to IDLE.
REQ-010 Latency: out_valid SHALL be high in the cycle after the K-th edge following the accept edge (K=4 by default). Throughput: one block per K+2 cycles with out_ready held high.
REQ-011 in_ready SHALL be 0 in SUB and DONE. in_valid and in_inv in those states SHALL be ignored, with no capture.
REQ-012 When INV_EN=0, in_inv SHALL be ignored and forward substitution always used.
REQ-013 Table contents SHALL be the FIPS-197 forward S-box and its exact inverse, implemented as combinational constant logic (no initial-block loading), so the block is synthesizable.
REQ-014 out_data SHALL show the register contents in every state. It is only meaningful when out_valid=1.
REQ-015 in_ready, out_valid and busy SHALL be decoded directly from the FSM state, with no combinational path from in_valid or out_ready.

Reset
REQ-016 rst_n low SHALL asynchronously force, regardless of clk:
- state=IDLE, cnt=0, byte register=0, mode=0;
- in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-017 Reset asserted in SUB or DONE SHALL discard the block in progress with no out_valid pulse. The first edge after deassertion SHALL be able to accept new input.

Verification
REQ-018 Forward, defaults. Accept in_data bytes 0..15 = 00,53,FF,01,10,20,...(rest 00), in_inv=0 -> after 4 cycles out_valid=1; bytes 0..3 = 63,ED,16,7C; bytes 4,5 = CA,B7.
REQ-019 Inverse. Bytes 63,ED,16,7C, in_inv=1 -> bytes 00,53,FF,01. With INV_EN=0, the same stimulus -> FB,55,47,10.
REQ-020 Back-pressure:
- Hold out_ready=0 for 3 cycles in DONE -> out_data stable, in_ready=0.
- in_valid pulsed during SUB -> not captured.
- Then out_ready=1 -> IDLE next cycle.
REQ-021 Exhaustive round trip for LANES in {1,4,16} and NUM_BYTES in {4,16}: all 256 byte values forward, then inverse -> originals restored; latency exactly K each time.
REQ-022 Reset: assert rst_n=0 mid-SUB (cnt=2) -> immediately out_valid=0, in_ready=1, out_data=0. Release -> the next block completes with correct data.
REQ-023 Elaboration with NUM_BYTES=16, LANES=3 SHALL fail.
